// File: rtl/lon_pkg.sv
// lon_pkg: shared types and helpers for the leading/trailing-one normaliser.
//   lon_mode_e : search direction (LON_LEAD = highest set bit, LON_TRAIL = lowest)
//   lon_idx_w  : width of the signed result index for a given operand width
//   lon_pos_w  : width of an unsigned position within an n-bit vector (min 1)
package lon_pkg;

  typedef enum logic {
    LON_LEAD  = 1'b0,
    LON_TRAIL = 1'b1
  } lon_mode_e;

  function automatic int lon_idx_w(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int lon_pos_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lon_group_search.sv
// lon_group_search: combinational find-first over a W-bit vector.
//   Parameters: W   - vector width
//               DIR - LON_LEAD finds the highest set bit, LON_TRAIL the lowest
//   Ports:      i_vec [W-1:0]  vector to search
//               o_hit          any bit set
//               o_pos [PW-1:0] position of the selected bit (0 when no hit)
module lon_group_search
  import lon_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter lon_mode_e   DIR = LON_LEAD,
  localparam int unsigned PW = lon_pos_w(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic          o_hit,
  output logic [PW-1:0] o_pos
);

  // Later matches overwrite earlier ones, so the scan order picks the winner.
  always_comb begin
    o_hit = |i_vec;
    o_pos = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (DIR == LON_LEAD) begin
        if (i_vec[i]) o_pos = PW'(i);
      end else begin
        if (i_vec[W-1-i]) o_pos = PW'(W-1-i);
      end
    end
  end

endmodule

// File: rtl/lead_one_norm_pipe.sv
// lead_one_norm_pipe: two-stage pipelined leading/trailing-one detector with
// normalising shift and valid/ready flow control.
//   S1 registers the operand, mode, tag and a per-CHUNK group-hit vector.
//   S2 picks the group, finds the bit within it, and registers idx/shamt/data.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        input handshake (in_ready independent of in_valid)
//   in_data [WIDTH]          operand
//   in_mode                  0 = leading one, 1 = trailing one
//   in_tag  [TAG_W]          sideband, returned with the result
//   out_valid/out_ready      output handshake
//   out_idx [IDX_W]          bit index, all-ones when operand is zero
//   out_zero                 operand was zero
//   out_shamt [IDX_W-1]      shift applied
//   out_data [WIDTH]         normalised operand
//   out_tag [TAG_W]          tag of this result
// Optional (macro LON_STATS_EN):
//   zero_cnt [16]            saturating count of delivered zero results
//   zero_cnt_clr             synchronous clear, wins over increment
module lead_one_norm_pipe
  import lon_pkg::*;
#(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned CHUNK = 4,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned IDX_W = lon_idx_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_zero,
  output logic [IDX_W-2:0]   out_shamt,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
`ifdef LON_STATS_EN
  ,
  output logic [15:0]        zero_cnt,
  input  logic               zero_cnt_clr
`endif
);

  localparam int unsigned G    = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned PADW = G * CHUNK;
  localparam int unsigned GPW  = lon_pos_w(G);
  localparam int unsigned CPW  = lon_pos_w(CHUNK);
  localparam int unsigned SW   = IDX_W - 1;

  // Stage 1 state
  logic               r_s1_v;
  logic [WIDTH-1:0]   r_s1_data;
  lon_mode_e          r_s1_mode;
  logic [TAG_W-1:0]   r_s1_tag;
  logic [G-1:0]       r_s1_ghit;

  // Stage 2 state
  logic               r_s2_v;
  logic [IDX_W-1:0]   r_s2_idx;
  logic               r_s2_zero;
  logic [SW-1:0]      r_s2_shamt;
  logic [WIDTH-1:0]   r_s2_data;
  logic [TAG_W-1:0]   r_s2_tag;

  // Flow control
  logic w_s2_free, w_acc, w_adv, w_out_xfer;

  assign w_s2_free  = !r_s2_v || out_ready;
  assign in_ready   = !r_s1_v || w_s2_free;
  assign w_acc      = in_valid && in_ready;
  assign w_adv      = r_s1_v && w_s2_free;
  assign w_out_xfer = r_s2_v && out_ready;

  // Stage 1 coarse search: one OR per group, top group zero-padded
  logic [PADW-1:0] w_in_pad;
  logic [G-1:0]    w_ghit;

  always_comb begin
    w_in_pad = PADW'(in_data);
    w_ghit   = '0;
    for (int unsigned g = 0; g < G; g++) begin
      w_ghit[g] = |w_in_pad[g*CHUNK +: CHUNK];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_mode <= LON_LEAD;
      r_s1_tag  <= '0;
      r_s1_ghit <= '0;
    end else begin
      if (w_acc) begin
        r_s1_v    <= 1'b1;
        r_s1_data <= in_data;
        r_s1_mode <= lon_mode_e'(in_mode);
        r_s1_tag  <= in_tag;
        r_s1_ghit <= w_ghit;
      end else if (w_adv) begin
        r_s1_v <= 1'b0;
      end
    end
  end

  // Stage 2: group select (both directions), then fine search in that group
  logic            w_gl_hit, w_gt_hit, w_fl_hit, w_ft_hit;
  logic [GPW-1:0]  w_gl_pos, w_gt_pos, w_gsel;
  logic [CPW-1:0]  w_fl_pos, w_ft_pos, w_fsel;
  logic [PADW-1:0] w_s1_pad;
  logic [CHUNK-1:0] w_chunk;

  lon_group_search #(.W(G), .DIR(LON_LEAD)) u_grp_lead (
    .i_vec (r_s1_ghit),
    .o_hit (w_gl_hit),
    .o_pos (w_gl_pos)
  );

  lon_group_search #(.W(G), .DIR(LON_TRAIL)) u_grp_trail (
    .i_vec (r_s1_ghit),
    .o_hit (w_gt_hit),
    .o_pos (w_gt_pos)
  );

  assign w_gsel   = (r_s1_mode == LON_TRAIL) ? w_gt_pos : w_gl_pos;
  assign w_s1_pad = PADW'(r_s1_data);
  assign w_chunk  = w_s1_pad[w_gsel*CHUNK +: CHUNK];

  lon_group_search #(.W(CHUNK), .DIR(LON_LEAD)) u_fine_lead (
    .i_vec (w_chunk),
    .o_hit (w_fl_hit),
    .o_pos (w_fl_pos)
  );

  lon_group_search #(.W(CHUNK), .DIR(LON_TRAIL)) u_fine_trail (
    .i_vec (w_chunk),
    .o_hit (w_ft_hit),
    .o_pos (w_ft_pos)
  );

  assign w_fsel = (r_s1_mode == LON_TRAIL) ? w_ft_pos : w_fl_pos;

  logic             w_zero;
  logic [31:0]      w_idx_full;
  logic [SW-1:0]    w_pos;
  logic [IDX_W-1:0] w_idx;
  logic [SW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_norm;

  always_comb begin
    w_zero     = (r_s1_mode == LON_TRAIL) ? !(w_gt_hit && w_ft_hit)
                                          : !(w_gl_hit && w_fl_hit);
    w_idx_full = 32'(w_gsel) * CHUNK + 32'(w_fsel);
    w_pos      = SW'(w_idx_full);
    w_idx      = {1'b0, w_pos};
    w_shamt    = (r_s1_mode == LON_TRAIL) ? w_pos : (SW'(WIDTH - 1) - w_pos);
    w_norm     = (r_s1_mode == LON_TRAIL) ? (r_s1_data >> w_shamt)
                                          : (r_s1_data << w_shamt);
    if (w_zero) begin
      w_idx   = '1;
      w_shamt = '0;
      w_norm  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v     <= 1'b0;
      r_s2_idx   <= '1;
      r_s2_zero  <= 1'b1;
      r_s2_shamt <= '0;
      r_s2_data  <= '0;
      r_s2_tag   <= '0;
    end else begin
      if (w_adv) begin
        r_s2_v     <= 1'b1;
        r_s2_idx   <= w_idx;
        r_s2_zero  <= w_zero;
        r_s2_shamt <= w_shamt;
        r_s2_data  <= w_norm;
        r_s2_tag   <= r_s1_tag;
      end else if (w_out_xfer) begin
        r_s2_v <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign out_idx   = r_s2_idx;
  assign out_zero  = r_s2_zero;
  assign out_shamt = r_s2_shamt;
  assign out_data  = r_s2_data;
  assign out_tag   = r_s2_tag;

`ifdef LON_STATS_EN
  logic [15:0] r_zero_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero_cnt <= '0;
    end else if (zero_cnt_clr) begin
      r_zero_cnt <= '0;
    end else if (w_out_xfer && r_s2_zero && (r_zero_cnt != '1)) begin
      r_zero_cnt <= r_zero_cnt + 16'd1;
    end
  end

  assign zero_cnt = r_zero_cnt;
`endif

endmodule
